// File: rtl/forward_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the forwarding / load-use hazard controller.
package forward_hazard_ctrl_pkg;

  // fwd_sel value meaning "take the operand from the register file"
  localparam int FWD_RF = 0;

  // Decode-hold controller state
  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/forward_hazard_ctrl_fwd_match.sv
// One source operand compared against the producer history.
// Returns the forwarding source (youngest match) and whether that producer is
// a load whose data is not yet available.
module fwd_match
  import forward_hazard_ctrl_pkg::*;
#(
  parameter int AW       = 4,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 0,
  parameter int SW       = 2
) (
  input  logic [AW-1:0]       src,
  input  logic                used,
  input  logic [DEPTH-1:0]    hist_valid,
  input  logic [DEPTH*AW-1:0] hist_dst,
  input  logic [DEPTH-1:0]    hist_load,
  output logic [SW-1:0]       sel,
  output logic                hazard
);

  logic zero_src;

  assign zero_src = (ZERO_REG != 0) && (src == '0);

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel    = SW'(FWD_RF);
    hazard = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (used && !zero_src && hist_valid[j] && (hist_dst[j*AW +: AW] == src)) begin
        if (hist_load[j] && ((j + 1) <= LOAD_LAT)) begin
          sel    = SW'(FWD_RF);
          hazard = 1'b1;
        end else begin
          sel    = SW'(j + 1);
          hazard = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding select and load-use stall generation for the decode stage.
// History entry j (0-based) holds the producer j+1 stages older than decode.
module forward_hazard_ctrl
  import forward_hazard_ctrl_pkg::*;
#(
  parameter int AW       = 4,
  parameter int NSRC     = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 0,
  localparam int SW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  input  logic [NSRC*AW-1:0] src_addr,
  input  logic [NSRC-1:0]    src_used,
  input  logic [AW-1:0]      dst_addr,
  input  logic               reg_write,
  input  logic               mem_to_reg,
  input  logic               flush,
  output logic [NSRC*SW-1:0] fwd_sel,
  output logic               stall,
  output logic [15:0]        stall_cycles
);

  localparam int CW = $clog2(LOAD_LAT + 2);

  logic [DEPTH-1:0]    hist_valid;
  logic [DEPTH*AW-1:0] hist_dst;
  logic [DEPTH-1:0]    hist_load;
  logic [NSRC-1:0]     op_hazard;
  logic                ins_valid;
  logic                stall_cap;

  ctrl_state_t         state_q, state_d;
  logic [CW-1:0]       consec_q, consec_d;

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_op
      fwd_match #(
        .AW       (AW),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .ZERO_REG (ZERO_REG),
        .SW       (SW)
      ) u_match (
        .src        (src_addr[g*AW +: AW]),
        .used       (src_used[g]),
        .hist_valid (hist_valid),
        .hist_dst   (hist_dst),
        .hist_load  (hist_load),
        .sel        (fwd_sel[g*SW +: SW]),
        .hazard     (op_hazard[g])
      );
    end
  endgenerate

  // A stalled or flushed instruction leaves a bubble behind it.
  assign ins_valid = issue_valid & reg_write & ~stall & ~flush;

  // Never hold decode longer than a load needs to become forwardable.
  assign stall_cap = (state_q == STALL) && (consec_q >= CW'(LOAD_LAT));
  assign stall     = issue_valid & ~flush & (|op_hazard) & ~stall_cap;

  // Producer history: shifts every cycle, youngest enters at entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_valid <= '0;
      hist_dst   <= '0;
      hist_load  <= '0;
    end else begin
      hist_valid <= {hist_valid[DEPTH-2:0], ins_valid};
      hist_dst   <= {hist_dst[(DEPTH-1)*AW-1:0], dst_addr};
      hist_load  <= {hist_load[DEPTH-2:0], mem_to_reg};
    end
  end

  // Controller state and consecutive-stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      consec_q <= '0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
    end
  end

  // RUN/STALL next state; counter tracks how long the current stall has run.
  always_comb begin
    state_d  = state_q;
    consec_d = consec_q;
    case (state_q)
      RUN: begin
        if (stall) begin
          state_d  = STALL;
          consec_d = CW'(1);
        end else begin
          consec_d = '0;
        end
      end
      STALL: begin
        if (stall) begin
          if (consec_q < CW'(LOAD_LAT)) consec_d = consec_q + CW'(1);
        end else begin
          state_d  = RUN;
          consec_d = '0;
        end
      end
      default: begin
        state_d  = RUN;
        consec_d = '0;
      end
    endcase
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  stall_cycles <= '0;
    else if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Scoreboard bench: two controllers (ZERO_REG=0 and ZERO_REG=1) share stimulus;
// a reference model predicts each cycle's outputs, a monitor checks them.
module tb_forward_hazard_ctrl;

  localparam int AW = 4, NSRC = 2, DEPTH = 2, LOAD_LAT = 1, SW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               issue_valid;
  logic [NSRC*AW-1:0] src_addr;
  logic [NSRC-1:0]    src_used;
  logic [AW-1:0]      dst_addr;
  logic               reg_write, mem_to_reg, flush;
  logic [NSRC*SW-1:0] fwd_sel0, fwd_sel1;
  logic               stall0, stall1;
  logic [15:0]        sc0, sc1;

  always #5 clk = ~clk;

  forward_hazard_ctrl #(.AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src_addr(src_addr), .src_used(src_used),
    .dst_addr(dst_addr), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .flush(flush),
    .fwd_sel(fwd_sel0), .stall(stall0), .stall_cycles(sc0));

  forward_hazard_ctrl #(.AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src_addr(src_addr), .src_used(src_used),
    .dst_addr(dst_addr), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .flush(flush),
    .fwd_sel(fwd_sel1), .stall(stall1), .stall_cycles(sc1));

  typedef struct packed {
    logic [NSRC*SW-1:0] sel;
    logic               st;
    logic [15:0]        sc;
  } obs_t;
  typedef struct packed { obs_t a; obs_t b; } exp_t;

  typedef struct { bit v; int dst; bit ld; } ent_t;

  exp_t expq[$];
  ent_t h[2][DEPTH];   // h[m][0] = producer one stage older than decode
  int   sc[2];
  bit   last_stall;
  int   total = 0, bad = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // Monitor: compare whatever the DUTs show this cycle against the queued prediction.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("fwd_sel_z0", 32'(fwd_sel0), 32'(e.a.sel));
      chk("stall_z0",   32'(stall0),   32'(e.a.st));
      chk("cycles_z0",  32'(sc0),      32'(e.a.sc));
      chk("fwd_sel_z1", 32'(fwd_sel1), 32'(e.b.sel));
      chk("stall_z1",   32'(stall1),   32'(e.b.st));
      chk("cycles_z1",  32'(sc1),      32'(e.b.sc));
    end
  end

  function automatic void clear_model();
    for (int m = 0; m < 2; m++) begin
      sc[m] = 0;
      for (int k = 0; k < DEPTH; k++) h[m][k] = '{v: 1'b0, dst: 0, ld: 1'b0};
    end
    last_stall = 1'b0;
  endfunction

  // Youngest producer writing s decides: forward distance, or hazard if the load is too fresh.
  function automatic int pick(input int m, input int s, input bit u, output bit hz);
    hz = 1'b0;
    if (!u || (m == 1 && s == 0)) return 0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (h[m][k-1].v && h[m][k-1].dst == s) begin
        if (h[m][k-1].ld && k <= LOAD_LAT) begin
          hz = 1'b1;
          return 0;
        end
        return k;
      end
    end
    return 0;
  endfunction

  task automatic step(input bit iv, input int s0, input int s1, input bit [1:0] u,
                      input int d, input bit rw, input bit ld, input bit fl);
    obs_t o[2];
    exp_t e;
    @(posedge clk); #1;
    issue_valid = iv;
    src_addr    = {AW'(s1), AW'(s0)};
    src_used    = u;
    dst_addr    = AW'(d);
    reg_write   = rw;
    mem_to_reg  = ld;
    flush       = fl;
    for (int m = 0; m < 2; m++) begin
      bit hz0, hz1, st;
      int p0, p1;
      p0 = pick(m, s0, u[0], hz0);
      p1 = pick(m, s1, u[1], hz1);
      st = iv && !fl && (hz0 || hz1);
      o[m].sel = {SW'(p1), SW'(p0)};
      o[m].st  = st;
      o[m].sc  = 16'(sc[m]);
      for (int k = DEPTH - 1; k > 0; k--) h[m][k] = h[m][k-1];
      h[m][0] = '{v: (iv && rw && !st && !fl), dst: d, ld: ld};
      if (st && sc[m] < 65535) sc[m]++;
      if (m == 0) last_stall = st;
    end
    e.a = o[0];
    e.b = o[1];
    expq.push_back(e);
  endtask

  // Reset for one cycle while leaving the current inputs in place.
  task automatic pulse_reset();
    exp_t e;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    e = '0;
    expq.push_back(e);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bit iv, rw, ld, fl;
    bit [1:0] u;
    int s0, s1, d;
    exp_t e0;
    rst = 1'b1;
    issue_valid = 1'b0; src_addr = '0; src_used = '0; dst_addr = '0;
    reg_write = 1'b0; mem_to_reg = 1'b0; flush = 1'b0;
    clear_model();
    #1;
    e0 = '0;
    expq.push_back(e0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ALU producer forwarded from one and two stages back
    step(1, 0, 0, 2'b00, 3, 1, 0, 0);
    step(1, 3, 0, 2'b01, 0, 0, 0, 0);
    step(1, 0, 0, 2'b00, 3, 1, 0, 0);
    step(1, 0, 0, 2'b00, 7, 0, 0, 0);
    step(1, 0, 3, 2'b10, 0, 0, 0, 0);
    // load-use: one stall, then forward from two stages back
    step(1, 0, 0, 2'b00, 5, 1, 1, 0);
    step(1, 0, 5, 2'b10, 0, 0, 0, 0);
    step(1, 0, 5, 2'b10, 0, 0, 0, 0);
    // same register written twice, youngest wins; both operands same register
    step(1, 0, 0, 2'b00, 4, 1, 0, 0);
    step(1, 0, 0, 2'b00, 4, 1, 0, 0);
    step(1, 4, 4, 2'b11, 0, 0, 0, 0);
    // write r0 then read it: hardwired zero only in the ZERO_REG=1 instance
    step(1, 0, 0, 2'b00, 0, 1, 0, 0);
    step(1, 0, 0, 2'b11, 0, 0, 0, 0);
    // flush during load-use: no stall, flushed writer of r6 becomes a bubble
    step(1, 0, 0, 2'b00, 5, 1, 1, 0);
    step(1, 5, 0, 2'b01, 6, 1, 0, 1);
    step(1, 5, 6, 2'b11, 0, 0, 0, 0);
    // reset in the middle of a stall discards the load
    step(1, 0, 0, 2'b00, 5, 1, 1, 0);
    step(1, 0, 5, 2'b10, 0, 0, 0, 0);
    pulse_reset();
    step(1, 0, 5, 2'b10, 0, 0, 0, 0);

    // randomized traffic; a stalled instruction is re-presented unchanged
    iv = 0; s0 = 0; s1 = 0; u = 0; d = 0; rw = 0; ld = 0; fl = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) pulse_reset();
      if (!last_stall) begin
        iv = ($urandom_range(0, 3) != 0);
        s0 = $urandom_range(0, 7);
        s1 = $urandom_range(0, 7);
        u  = 2'($urandom_range(0, 3));
        d  = $urandom_range(0, 7);
        rw = ($urandom_range(0, 3) != 0);
        ld = ($urandom_range(0, 2) == 0);
        fl = ($urandom_range(0, 9) == 0);
      end
      step(iv, s0, s1, u, d, rw, ld, fl);
    end

    repeat (3) @(posedge clk);
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain got=%0d expected=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
